// File: rtl/alu_pkg.sv
// Opcode encodings, FSM state type and opcode classification helpers for alu_md.
package alu_pkg;

  localparam int unsigned OPW = 5;
  typedef logic [OPW-1:0] op_t;

  localparam op_t ALU_ADD    = 5'd0;
  localparam op_t ALU_SUB    = 5'd1;
  localparam op_t ALU_SLT    = 5'd2;
  localparam op_t ALU_SLTU   = 5'd3;
  localparam op_t ALU_SGE    = 5'd4;
  localparam op_t ALU_SGEU   = 5'd5;
  localparam op_t ALU_AND    = 5'd6;
  localparam op_t ALU_OR     = 5'd7;
  localparam op_t ALU_XOR    = 5'd8;
  localparam op_t ALU_SEQ    = 5'd9;
  localparam op_t ALU_SNE    = 5'd10;
  localparam op_t ALU_SL     = 5'd11;
  localparam op_t ALU_SR     = 5'd12;
  localparam op_t ALU_SRA    = 5'd13;
  localparam op_t ALU_MUL    = 5'd16;
  localparam op_t ALU_MULH   = 5'd17;
  localparam op_t ALU_MULHSU = 5'd18;
  localparam op_t ALU_MULHU  = 5'd19;
  localparam op_t ALU_DIV    = 5'd20;
  localparam op_t ALU_DIVU   = 5'd21;
  localparam op_t ALU_REM    = 5'd22;
  localparam op_t ALU_REMU   = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_long_op(input op_t op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_mul_op(input op_t op);
    return (op >= ALU_MUL) && (op <= ALU_MULHU);
  endfunction

  function automatic logic is_div_op(input op_t op);
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction

  // rs1 interpreted as two's complement
  function automatic logic is_signed_op(input op_t op);
    return op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  endfunction

  // rs2 interpreted as two's complement
  function automatic logic rs2_signed_op(input op_t op);
    return op inside {ALU_MULH, ALU_DIV, ALU_REM};
  endfunction

  // result taken from the upper half (high product word or remainder)
  function automatic logic is_hi_op(input op_t op);
    return op inside {ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/alu_md_muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring) engine, one result bit per cycle.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] oper1,
  input  logic [XLEN-1:0] oper2,
  output logic            done_c,
  output logic [XLEN-1:0] result_c
);

  localparam int unsigned W2 = 2 * XLEN;

  logic [W2-1:0]   acc_q, acc_nxt;
  logic [XLEN-1:0] opnd_q;
  logic [CNTW-1:0] cnt_q;
  logic            mul_q, hi_q, neg_q;

  logic            s1_c, s2_c;
  logic [XLEN-1:0] mag1_c, mag2_c;
  logic [XLEN:0]   sum_c, rem_sh_c, diff_c;
  logic [W2-1:0]   prod_fix_c;
  logic [XLEN-1:0] div_sel_c;

  // Operand magnitudes and sign flags at start
  always_comb begin
    s1_c   = is_signed_op(op) & oper1[XLEN-1];
    s2_c   = rs2_signed_op(op) & oper2[XLEN-1];
    mag1_c = s1_c ? -oper1 : oper1;
    mag2_c = s2_c ? -oper2 : oper2;
  end

  // One iteration: acc = {partial product | remainder, multiplier | dividend/quotient}
  always_comb begin
    sum_c    = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    rem_sh_c = acc_q[W2-1:XLEN-1];
    diff_c   = rem_sh_c - {1'b0, opnd_q};
    if (mul_q) begin
      acc_nxt = {sum_c, acc_q[XLEN-1:1]};
    end else begin
      acc_nxt = {(diff_c[XLEN] ? rem_sh_c[XLEN-1:0] : diff_c[XLEN-1:0]),
                 acc_q[XLEN-2:0], ~diff_c[XLEN]};
    end
  end

  // Sign fix-up applied to the final iteration's value
  always_comb begin
    prod_fix_c = neg_q ? -acc_nxt : acc_nxt;
    div_sel_c  = hi_q ? acc_nxt[W2-1:XLEN] : acc_nxt[XLEN-1:0];
    if (mul_q) begin
      result_c = hi_q ? prod_fix_c[W2-1:XLEN] : prod_fix_c[XLEN-1:0];
    end else begin
      result_c = neg_q ? -div_sel_c : div_sel_c;
    end
    done_c = (cnt_q == CNTW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      mul_q  <= 1'b0;
      hi_q   <= 1'b0;
      neg_q  <= 1'b0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q  <= CNTW'(XLEN);
      mul_q  <= is_mul_op(op);
      hi_q   <= is_hi_op(op);
      // remainder takes the dividend's sign, everything else the xor of signs
      neg_q  <= (op == ALU_REM) ? s1_c : (s1_c ^ s2_c);
      opnd_q <= is_mul_op(op) ? mag1_c : mag2_c;
      acc_q  <= {{XLEN{1'b0}}, (is_mul_op(op) ? mag2_c : mag1_c)};
    end else if (cnt_q != '0) begin
      acc_q <= acc_nxt;
      cnt_q <= cnt_q - CNTW'(1);
    end
  end

endmodule

// File: rtl/alu_md.sv
// Handshaked EX-stage integer ALU with RV32M/RV64M multiply/divide.
// Define FAST_MUL_EN for single-cycle multiplies; divides always iterate.
module alu_md
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN),
  parameter int unsigned CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] oper1,
  input  logic [XLEN-1:0] oper2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  state_t          state_q, state_nxt;
  logic            accept_c, go_long_c, eng_start_c, eng_done_c;
  logic            div_zero_c, div_ovf_c, special_c, fast_mul_c;
  logic [XLEN-1:0] special_res_c, fast_res_c, short_res_c, eng_res_c;
  logic [SHW-1:0]  shamt;

  assign shamt = oper2[SHW-1:0];

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] ext1_c, ext2_c, fprod_c;

  // Extend to 2*XLEN so a modular product yields the signed/unsigned high word
  always_comb begin
    ext1_c     = {{XLEN{is_signed_op(alu_op) & oper1[XLEN-1]}}, oper1};
    ext2_c     = {{XLEN{rs2_signed_op(alu_op) & oper2[XLEN-1]}}, oper2};
    fprod_c    = ext1_c * ext2_c;
    fast_res_c = is_hi_op(alu_op) ? fprod_c[2*XLEN-1:XLEN] : fprod_c[XLEN-1:0];
  end
  assign fast_mul_c = is_mul_op(alu_op);
`else
  assign fast_res_c = '0;
  assign fast_mul_c = 1'b0;
`endif

  // Divide corner cases resolved at accept without iterating
  always_comb begin
    div_zero_c = is_div_op(alu_op) & (oper2 == '0);
    div_ovf_c  = ((alu_op == ALU_DIV) | (alu_op == ALU_REM)) &
                 (oper1 == MIN_NEG) & (oper2 == ALL_ONES);
    special_c  = div_zero_c | div_ovf_c;
    if (div_zero_c) special_res_c = is_hi_op(alu_op) ? oper1 : ALL_ONES;
    else            special_res_c = is_hi_op(alu_op) ? '0 : oper1;
    go_long_c  = is_long_op(alu_op) & ~special_c & ~fast_mul_c;
  end

  // Single-cycle datapath; unknown opcodes fall through to ADD
  always_comb begin
    short_res_c = oper1 + oper2;
    case (alu_op)
      ALU_SUB:  short_res_c = oper1 - oper2;
      ALU_SLT:  short_res_c = XLEN'($signed(oper1) < $signed(oper2));
      ALU_SLTU: short_res_c = XLEN'(oper1 < oper2);
      ALU_SGE:  short_res_c = XLEN'($signed(oper1) >= $signed(oper2));
      ALU_SGEU: short_res_c = XLEN'(oper1 >= oper2);
      ALU_AND:  short_res_c = oper1 & oper2;
      ALU_OR:   short_res_c = oper1 | oper2;
      ALU_XOR:  short_res_c = oper1 ^ oper2;
      ALU_SEQ:  short_res_c = XLEN'(oper1 == oper2);
      ALU_SNE:  short_res_c = XLEN'(oper1 != oper2);
      ALU_SL:   short_res_c = oper1 << shamt;
      ALU_SR:   short_res_c = oper1 >> shamt;
      ALU_SRA:  short_res_c = $signed(oper1) >>> shamt;
      default: begin
        if (special_c)       short_res_c = special_res_c;
        else if (fast_mul_c) short_res_c = fast_res_c;
      end
    endcase
  end

  muldiv_iter #(
    .XLEN (XLEN),
    .CNTW (CNTW)
  ) u_muldiv_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (eng_start_c),
    .flush    (flush),
    .op       (alu_op),
    .oper1    (oper1),
    .oper2    (oper2),
    .done_c   (eng_done_c),
    .result_c (eng_res_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      out_valid <= (state_nxt == ST_DONE);
      busy      <= (state_nxt == ST_BUSY);
    end
  end

  // Next state; flush wins over any request or completion
  always_comb begin
    state_nxt = state_q;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) state_nxt = go_long_c ? ST_BUSY : ST_DONE;
        end
        ST_BUSY: begin
          if (eng_done_c) state_nxt = ST_DONE;
        end
        ST_DONE: begin
          if (accept_c)       state_nxt = go_long_c ? ST_BUSY : ST_DONE;
          else if (out_ready) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Handshake decode
  always_comb begin
    in_ready    = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    accept_c    = in_valid & in_ready & ~flush;
    eng_start_c = accept_c & go_long_c;
  end

  // Result register holds until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out <= '0;
    end else if (accept_c && !go_long_c) begin
      alu_out <= short_res_c;
    end else if ((state_q == ST_BUSY) && eng_done_c && !flush) begin
      alu_out <= eng_res_c;
    end
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised, handshaked successor to the single-cycle integer ALU.
- Adds registered output, valid/ready flow control, and RV32M/RV64M multiply/divide/remainder via an iterative shift-add/restoring-divide engine.
- Sits in EX stage; pipeline stalls on in_ready low; flush aborts an in-flight long op.

Parameters:
XLEN, 32, operand/result width (32 or 64)
SHW, $clog2(XLEN), shift-amount width taken from oper2[SHW-1:0]
CNTW, $clog2(XLEN)+1, iteration counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  abort current op, return to IDLE next edge
in_valid  input  1  operation request
in_ready  output  1  block can accept request this cycle
alu_op  input  5  operation code (alu_pkg encodings)
oper1  input  XLEN  operand 1 (rs1)
oper2  input  XLEN  operand 2 (rs2/imm)
out_valid  output  1  alu_out valid
out_ready  input  1  consumer accepts result
alu_out  output  XLEN  result
busy  output  1  long op iterating (state BUSY)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, alu_out=0, busy=0, counter=0; in_ready=1 after reset.
- States: IDLE, BUSY, DONE.
- Accept = in_valid & in_ready; in_ready = (state==IDLE) | (state==DONE & out_ready); in_ready=0 in BUSY.
- Short ops (ADD SUB SLT SLTU SGE SGEU AND OR XOR SEQ SNE SL SR SRA): result registered on accept edge, state->DONE; latency 1 cycle. Compares zero-extend 1-bit result to XLEN. SRA sign-fills; shifts use oper2[SHW-1:0]. Unknown op -> ADD.
- Long ops (MUL MULH MULHSU MULHU DIV DIVU REM REMU): operands captured (magnitudes + result-sign flag for signed forms), counter=XLEN, state->BUSY; one bit per cycle; counter==1 on final iteration -> sign fix-up, alu_out written, state->DONE. Latency XLEN+1 cycles accept-to-out_valid.
- DONE: out_valid=1, alu_out stable until out_ready=1. out_ready & in_valid in DONE: back-to-back accept, no bubble. out_ready without new request -> IDLE.
- MUL returns low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of 2*XLEN product.
- Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = oper1. Detected at accept; latency 1, no iteration.
- Signed overflow (oper1 = most-negative, oper2 = -1): DIV = oper1, REM = 0; latency 1.
- flush: highest priority after reset; any state -> IDLE next edge, out_valid=0, counter cleared; a same-cycle request is dropped.
- Async reset mid-BUSY: immediate IDLE, no result produced.
- Operand inputs ignored outside accept cycle.

Optional Feature:
- FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a combinational XLEN x XLEN multiplier; latency 1 like short ops; divide stays iterative.
- Not defined: multiplies iterate XLEN cycles as above.
- Encodings and ports unchanged either way.

Decomposition:
- Package alu_pkg:
  - ALU_* op localparams (5-bit; existing 14 codes keep values 0-13, M ops 16-23)
  - state encoding
  - helper is_long_op/is_signed_op functions
- One sub-module muldiv_iter: iterative engine with start/flush/op/operands in, done/result out, counter and partial product/remainder registers. alu_md owns the FSM, handshake and short-op datapath.

Test Plan:
- ADD 0x7FFFFFFF+1, out_ready=1 -> alu_out=0x80000000 one cycle after accept; SRA 0x80000000 by 31 -> 0xFFFFFFFF; SLT -1,1 -> 1.
- DIV -7/2 -> out_valid after 33 cycles, 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM -> 0, each latency 1.
- Result backpressure: out_ready=0 for 5 cycles -> out_valid, alu_out held, in_ready=0; then out_ready=1 & in_valid ADD 3+4 same cycle -> next result 7 with no bubble.
- flush at cycle 10 of DIVU -> IDLE next cycle, out_valid never asserted, next ADD 1+1 returns 2; rst_n pulse mid-BUSY -> all outputs reset immediately.
- Build with FAST_MUL_EN: MUL 6*7 -> 42 one cycle after accept; XLEN=64 DIV 0x8000000000000000/-1 -> 0x8000000000000000.
